// File: rtl/fc_relu_stage.sv
// Fully-connected layer with ReLU-saturate to 8 bits. For a valid header, dut_busy is high for exactly
// 2 + N_IN/2 + N_OUT*(N_IN/2 + 1) + ceil(N_OUT/2) + 1 cycles; for a rejected header it is high for 3 cycles.
module fc_relu_stage #(
  parameter int MAX_IN = 64,
  parameter int ACC_W  = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dut_run,
  output logic        dut_busy,
  output logic        fc_error,
  output logic [11:0] output_sram_read_address,
  input  logic [15:0] output_sram_read_data,
  output logic [11:0] weights_sram_read_address,
  input  logic [15:0] weights_sram_read_data,
  output logic        scratchpad_sram_write_enable,
  output logic [11:0] scratchpad_sram_write_addresss,
  output logic [15:0] scratchpad_sram_write_data
);

  localparam int DEPTH = MAX_IN / 2;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [8:0] MAX_IN_L = 9'(MAX_IN);

  typedef enum logic [2:0] {IDLE, HDR, LOAD, MAC, POST, WRITE, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_half;
  logic [7:0]              r_nOut;
  logic [7:0]              r_neuron;
  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_hiByte;
  logic [15:0]             r_wdata;
  logic [11:0]             r_spAddr;
  logic [11:0]             r_waddr;
  logic [11:0]             r_faddr;
  logic                    r_fcError;
  logic [15:0]             r_feat [0:DEPTH-1];

  logic [7:0]              w_hdrIn;
  logic [7:0]              w_hdrOut;
  logic                    w_hdrBad;
  logic                    w_cntLast;
  logic                    w_lastNeuron;
  logic [15:0]             w_feat;
  logic signed [7:0]       w_fHi, w_fLo, w_wHi, w_wLo;
  logic signed [15:0]      w_prodHi, w_prodLo;
  logic signed [ACC_W-1:0] w_macSum;
  logic [7:0]              w_relu;

  assign w_hdrIn  = weights_sram_read_data[7:0];
  assign w_hdrOut = weights_sram_read_data[15:8];
  assign w_hdrBad = (w_hdrIn == 8'd0) || w_hdrIn[0] || ({1'b0, w_hdrIn} > MAX_IN_L) ||
                    (w_hdrOut == 8'd0);

  assign w_cntLast    = (r_cnt == r_half - CW'(1));
  assign w_lastNeuron = (r_neuron == r_nOut - 8'd1);

  // One feature word and one weight word per MAC cycle: two signed 8x8 products.
  assign w_feat   = r_feat[r_cnt[IW-1:0]];
  assign w_fHi    = w_feat[15:8];
  assign w_fLo    = w_feat[7:0];
  assign w_wHi    = weights_sram_read_data[15:8];
  assign w_wLo    = weights_sram_read_data[7:0];
  assign w_prodHi = 16'(w_fHi) * 16'(w_wHi);
  assign w_prodLo = 16'(w_fLo) * 16'(w_wLo);
  assign w_macSum = ACC_W'(w_prodHi) + ACC_W'(w_prodLo);

  always_comb begin
    w_relu = {1'b0, r_acc[6:0]};
    if (r_acc[ACC_W-1]) begin
      w_relu = 8'h00;
    end else if (|r_acc[ACC_W-2:7]) begin
      w_relu = 8'h7F;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (dut_run) w_next = HDR;
      HDR:   if (r_cnt[0]) w_next = w_hdrBad ? DONE : LOAD;
      LOAD:  if (w_cntLast) w_next = MAC;
      MAC:   if (w_cntLast) w_next = POST;
      POST:  w_next = (!r_neuron[0] && !w_lastNeuron) ? MAC : WRITE;
      WRITE: w_next = w_lastNeuron ? DONE : MAC;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Weight address runs one word ahead; it only moves on cycles that lead into MAC, so POST/WRITE stall it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_nOut    <= '0;
      r_neuron  <= '0;
      r_acc     <= '0;
      r_hiByte  <= '0;
      r_wdata   <= '0;
      r_spAddr  <= '0;
      r_waddr   <= '0;
      r_faddr   <= '0;
      r_fcError <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE || w_next != r_state) r_cnt <= '0;
      else r_cnt <= r_cnt + CW'(1);
      if (w_next == MAC) r_waddr <= r_waddr + 12'd1;
      case (r_state)
        IDLE: if (dut_run) begin
          r_fcError <= 1'b0;
          r_waddr   <= '0;
          r_faddr   <= '0;
        end
        HDR: if (r_cnt[0]) begin
          r_nOut   <= w_hdrOut;
          r_half   <= CW'(w_hdrIn[7:1]);
          r_neuron <= '0;
          r_waddr  <= 12'd1;
          r_faddr  <= 12'd1;
          if (w_hdrBad) r_fcError <= 1'b1;
        end
        LOAD: r_faddr <= r_faddr + 12'd1;
        MAC:  r_acc <= (r_cnt == '0) ? w_macSum : r_acc + w_macSum;
        POST: begin
          if (!r_neuron[0]) r_hiByte <= w_relu;
          r_wdata  <= r_neuron[0] ? {r_hiByte, w_relu} : {w_relu, 8'h00};
          r_spAddr <= {5'd0, r_neuron[7:1]};
        end
        default: ;
      endcase
      if ((r_state == POST || r_state == WRITE) && w_next == MAC) r_neuron <= r_neuron + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == LOAD) r_feat[r_cnt[IW-1:0]] <= output_sram_read_data;
  end

  assign dut_busy                       = (r_state != IDLE);
  assign fc_error                       = r_fcError;
  assign output_sram_read_address       = r_faddr;
  assign weights_sram_read_address      = r_waddr;
  assign scratchpad_sram_write_enable   = (r_state == WRITE);
  assign scratchpad_sram_write_addresss = r_spAddr;
  assign scratchpad_sram_write_data     = r_wdata;

endmodule

// File: tb/tb_fc_relu_stage.sv
// Self-checking bench for fc_relu_stage: SRAM models, a directed vector table, corner-case sequences
// and randomized runs scored against an arithmetic reference model.
module tb_fc_relu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        dut_run;
  logic        dut_busy;
  logic        fc_error;
  logic [11:0] output_sram_read_address;
  logic [15:0] output_sram_read_data;
  logic [11:0] weights_sram_read_address;
  logic [15:0] weights_sram_read_data;
  logic        scratchpad_sram_write_enable;
  logic [11:0] scratchpad_sram_write_addresss;
  logic [15:0] scratchpad_sram_write_data;

  always #5 clk = ~clk;

  fc_relu_stage #(.MAX_IN(64), .ACC_W(24)) dut (
    .clk                           (clk),
    .reset                         (reset),
    .dut_run                       (dut_run),
    .dut_busy                      (dut_busy),
    .fc_error                      (fc_error),
    .output_sram_read_address      (output_sram_read_address),
    .output_sram_read_data         (output_sram_read_data),
    .weights_sram_read_address     (weights_sram_read_address),
    .weights_sram_read_data        (weights_sram_read_data),
    .scratchpad_sram_write_enable  (scratchpad_sram_write_enable),
    .scratchpad_sram_write_addresss(scratchpad_sram_write_addresss),
    .scratchpad_sram_write_data    (scratchpad_sram_write_data)
  );

  logic [15:0] fMem [0:4095];
  logic [15:0] wMem [0:4095];

  always @(posedge clk) begin
    output_sram_read_data  <= fMem[output_sram_read_address];
    weights_sram_read_data <= wMem[weights_sram_read_address];
  end

  logic [11:0] wrAddrQ [$];
  logic [15:0] wrDataQ [$];

  always @(negedge clk) begin
    if (scratchpad_sram_write_enable) begin
      wrAddrQ.push_back(scratchpad_sram_write_addresss);
      wrDataQ.push_back(scratchpad_sram_write_data);
    end
  end

  typedef struct {
    int          nIn;
    int          nOut;
    bit          ramp;
    int          fVal;
    int          wVal;
    bit          expErr;
    int          expLat;
    int          expWrites;
    logic [15:0] expW0;
  } vec_t;

  localparam int LIMIT = 2000;

  int          nChecks = 0;
  int          nFails  = 0;
  int          featB [0:255];
  int          wtB   [0:1023];
  logic [15:0] expW  [0:127];
  vec_t        vecs  [0:10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fillPattern(input int nIn, input int nOut, input bit ramp, input int fVal, input int wVal);
    for (int i = 0; i < nIn; i++) featB[i] = ramp ? i + 1 : fVal;
    for (int k = 0; k < nIn * nOut; k++) wtB[k] = wVal;
  endtask

  task automatic loadMems(input int nIn, input int nOut);
    wMem[0] = {8'(nOut), 8'(nIn)};
    for (int i = 0; i < nIn / 2; i++) fMem[i] = {8'(featB[2*i]), 8'(featB[2*i+1])};
    for (int j = 0; j < nOut; j++)
      for (int i = 0; i < nIn / 2; i++)
        wMem[1 + j*(nIn/2) + i] = {8'(wtB[j*nIn + 2*i]), 8'(wtB[j*nIn + 2*i + 1])};
  endtask

  // Reference: dot product per neuron, clamp to [0,127], pack neuron pairs high byte first.
  task automatic computeModel(input int nIn, input int nOut, output bit err, output int lat, output int nWords);
    int sum;
    int r;
    err = (nIn == 0) || (nIn % 2 != 0) || (nIn > 64) || (nOut == 0);
    if (err) begin
      lat    = 3;
      nWords = 0;
      return;
    end
    for (int j = 0; j < nOut; j++) begin
      sum = 0;
      for (int i = 0; i < nIn; i++) sum += featB[i] * wtB[j*nIn + i];
      r = (sum < 0) ? 0 : (sum > 127) ? 127 : sum;
      if (j % 2 == 0) expW[j/2] = {8'(r), 8'h00};
      else expW[j/2][7:0] = 8'(r);
    end
    nWords = (nOut + 1) / 2;
    lat    = 2 + nIn/2 + nOut*(nIn/2 + 1) + nWords + 1;
  endtask

  task automatic applyStimulus(input bit holdRun, output int lat, output logic errStart, output logic errEnd);
    wrAddrQ.delete();
    wrDataQ.delete();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    if (!holdRun) dut_run = 1'b0;
    errStart = fc_error;
    lat = 0;
    while (dut_busy && lat < LIMIT) begin
      lat++;
      @(negedge clk);
    end
    dut_run = 1'b0;
    if (lat >= LIMIT) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL timeout: busy still 1 after %0d cycles, required 0", lat);
    end
    errEnd = fc_error;
  endtask

  task automatic checkWrites(input string tag, input int nWords);
    checkOutput($sformatf("%s.nwrites", tag), wrAddrQ.size(), nWords);
    for (int k = 0; k < nWords && k < wrAddrQ.size(); k++) begin
      checkOutput($sformatf("%s.addr%0d", tag, k), 32'(wrAddrQ[k]), k);
      checkOutput($sformatf("%s.data%0d", tag, k), 32'(wrDataQ[k]), 32'(expW[k]));
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    int   mLat;
    int   mWords;
    int   nIn;
    int   nOut;
    bit   mErr;
    bit   sawBusy;
    logic es;
    logic ee;

    vecs[0]  = '{4,  2, 1, 0,    1,    0, 12,  1, 16'h0A0A};
    vecs[1]  = '{64, 1, 0, -128, -128, 0, 69,  1, 16'h7F00};
    vecs[2]  = '{3,  2, 0, 1,    1,    1, 3,   0, 16'h0000};
    vecs[3]  = '{0,  1, 0, 1,    1,    1, 3,   0, 16'h0000};
    vecs[4]  = '{66, 1, 0, 1,    1,    1, 3,   0, 16'h0000};
    vecs[5]  = '{4,  0, 0, 1,    1,    1, 3,   0, 16'h0000};
    vecs[6]  = '{2,  1, 0, 10,   -1,   0, 7,   1, 16'h0000};
    vecs[7]  = '{2,  1, 0, 5,    6,    0, 7,   1, 16'h3C00};
    vecs[8]  = '{2,  1, 0, 8,    8,    0, 7,   1, 16'h7F00};
    vecs[9]  = '{64, 3, 0, 1,    1,    0, 136, 2, 16'h4040};
    vecs[10] = '{2,  2, 0, 127,  127,  0, 9,   1, 16'h7F7F};

    for (int i = 0; i < 4096; i++) begin
      fMem[i] = '0;
      wMem[i] = '0;
    end
    reset   = 1'b1;
    dut_run = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.busy", dut_busy, 0);
    checkOutput("rst.err", fc_error, 0);
    checkOutput("rst.we", scratchpad_sram_write_enable, 0);
    checkOutput("rst.faddr", output_sram_read_address, 0);
    checkOutput("rst.waddr", weights_sram_read_address, 0);
    checkOutput("rst.spaddr", scratchpad_sram_write_addresss, 0);
    reset = 1'b0;

    for (int v = 0; v < 11; v++) begin
      fillPattern(vecs[v].nIn, vecs[v].nOut, vecs[v].ramp, vecs[v].fVal, vecs[v].wVal);
      loadMems(vecs[v].nIn, vecs[v].nOut);
      applyStimulus(1'b0, lat, es, ee);
      checkOutput($sformatf("vec%0d.lat", v), lat, vecs[v].expLat);
      checkOutput($sformatf("vec%0d.err", v), ee, vecs[v].expErr);
      checkOutput($sformatf("vec%0d.nwrites", v), wrAddrQ.size(), vecs[v].expWrites);
      if (vecs[v].expWrites > 0 && wrAddrQ.size() > 0) begin
        checkOutput($sformatf("vec%0d.addr0", v), 32'(wrAddrQ[0]), 0);
        checkOutput($sformatf("vec%0d.data0", v), 32'(wrDataQ[0]), 32'(vecs[v].expW0));
      end
    end

    $display("[TB] odd neuron count with per-row weights");
    featB[0] = 100; featB[1] = 100;
    wtB[0] = 1;  wtB[1] = 1;
    wtB[2] = -1; wtB[3] = -1;
    wtB[4] = 0;  wtB[5] = 1;
    loadMems(2, 3);
    computeModel(2, 3, mErr, mLat, mWords);
    applyStimulus(1'b0, lat, es, ee);
    checkOutput("odd.lat", lat, 12);
    checkWrites("odd", mWords);
    if (wrDataQ.size() == 2) begin
      checkOutput("odd.word0", 32'(wrDataQ[0]), 32'h7F00);
      checkOutput("odd.word1", 32'(wrDataQ[1]), 32'h6400);
    end

    $display("[TB] header error then recovery");
    fillPattern(3, 1, 1'b0, 1, 1);
    loadMems(3, 1);
    applyStimulus(1'b0, lat, es, ee);
    checkOutput("hdrerr.err", ee, 1);
    checkOutput("hdrerr.nwrites", wrAddrQ.size(), 0);
    checkOutput("hdrerr.busy", dut_busy, 0);
    fillPattern(4, 2, 1'b1, 0, 1);
    loadMems(4, 2);
    computeModel(4, 2, mErr, mLat, mWords);
    applyStimulus(1'b0, lat, es, ee);
    checkOutput("recover.errAtStart", es, 0);
    checkOutput("recover.err", ee, 0);
    checkWrites("recover", mWords);

    $display("[TB] reset during second neuron");
    wrAddrQ.delete();
    wrDataQ.delete();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("midrst.busyBefore", dut_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst.busy", dut_busy, 0);
    checkOutput("midrst.we", scratchpad_sram_write_enable, 0);
    checkOutput("midrst.waddr", weights_sram_read_address, 0);
    checkOutput("midrst.spaddr", scratchpad_sram_write_addresss, 0);
    repeat (20) @(negedge clk);
    checkOutput("midrst.nwrites", wrAddrQ.size(), 0);
    applyStimulus(1'b0, lat, es, ee);
    checkOutput("midrst.rerunLat", lat, 12);
    checkWrites("midrst.rerun", mWords);

    $display("[TB] start together with reset");
    @(negedge clk);
    reset   = 1'b1;
    dut_run = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    dut_run = 1'b0;
    checkOutput("rstrun.busy0", dut_busy, 0);
    @(negedge clk);
    checkOutput("rstrun.busy1", dut_busy, 0);

    $display("[TB] run held high");
    applyStimulus(1'b1, lat, es, ee);
    checkOutput("hold.lat", lat, 12);
    checkWrites("hold", mWords);
    sawBusy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (dut_busy) sawBusy = 1'b1;
    end
    checkOutput("hold.idleAfter", sawBusy, 0);

    $display("[TB] randomized runs");
    for (int t = 0; t < 25; t++) begin
      nIn  = 2 * int'($urandom_range(1, 32));
      nOut = int'($urandom_range(1, 7));
      for (int i = 0; i < nIn; i++)
        featB[i] = (t % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
      for (int k = 0; k < nIn * nOut; k++)
        wtB[k] = (t % 2 == 0) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
      loadMems(nIn, nOut);
      computeModel(nIn, nOut, mErr, mLat, mWords);
      applyStimulus(1'b0, lat, es, ee);
      checkOutput($sformatf("rand%0d.lat", t), lat, mLat);
      checkOutput($sformatf("rand%0d.err", t), ee, mErr);
      checkWrites($sformatf("rand%0d", t), mWords);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fc_relu_stage.md
FC_RELU_STAGE -- requirements
Module: fc_relu_stage

Interface
REQ-001 Parameter MAX_IN, default 64: maximum input feature count, bytes buffered internally; even.
REQ-002 Parameter ACC_W, default 24: signed accumulator width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 dut_run  in  1  start request, sampled in IDLE only.
REQ-007 dut_busy  out  1  high from the cycle after start is accepted until the DONE cycle inclusive.
REQ-008 fc_error  out  1  sticky header-error flag, cleared on next accepted start.
REQ-009 output_sram_read_address  out  12  pooled feature-map read address; data from the upstream conv/pool stage.
REQ-010 output_sram_read_data  in  16  feature word: two signed 8-bit values, high byte first.
REQ-011 weights_sram_read_address  out  12  weight/header read address.
REQ-012 weights_sram_read_data  in  16  weight word: two signed 8-bit values, high byte first.
REQ-013 scratchpad_sram_write_enable  out  1  one-cycle write strobe.
REQ-014 scratchpad_sram_write_addresss  out  12  result word address.
REQ-015 scratchpad_sram_write_data  out  16  two 8-bit results, high byte first.

Function
REQ-016 Both SRAMs have one-cycle read latency: data for an address driven in cycle t is valid in cycle t+1.
REQ-017 Header: weights word 0 = {N_OUT[7:0], N_IN[7:0]}; weights for neuron j start at word 1 + j*(N_IN/2), row-major, two per word.
REQ-018 Features: N_IN bytes at output_sram words 0..N_IN/2-1; byte order high then low.
REQ-019 States: IDLE, HDR, LOAD, MAC, POST, WRITE, DONE.
REQ-020 IDLE -> HDR when dut_run=1; dut_run in any other state is ignored.
REQ-021 HDR: read weights word 0; N_IN=0, N_IN odd, N_IN>MAX_IN or N_OUT=0 sets fc_error and -> DONE with no writes.
REQ-022 LOAD: read N_IN/2 feature words at one address per cycle into internal buffer; -> MAC after last word is captured.
REQ-023 MAC: per cycle consume one weight word, acc += f[2k]*w_hi + f[2k+1]*w_lo, signed 8x8 products sign-extended to ACC_W; acc cleared at start of each neuron.
REQ-024 Weight address advances every MAC cycle without bubbles across neuron boundaries except one POST cycle.
REQ-025 POST: ReLU-saturate: acc<0 -> 0; acc>127 -> 127; else acc[7:0].
REQ-026 Even-indexed neuron result held in high byte; odd-indexed result completes the word -> WRITE.
REQ-027 Last neuron with N_OUT odd: word written as {result, 8'h00}.
REQ-028 WRITE: scratchpad_sram_write_enable=1 for exactly one cycle; address = j>>1, starting at 0, incrementing by 1.
REQ-029 After WRITE or POST, -> MAC for the next neuron, or -> DONE after neuron N_OUT-1.
REQ-030 DONE: one cycle, then -> IDLE; dut_busy drops in the IDLE cycle.
REQ-031 Total latency for valid header: fixed; 2 + N_IN/2 + N_OUT*(N_IN/2 + 1) + ceil(N_OUT/2) + 1 cycles (+/- pipeline flops), documented exactly in RTL header and checked by bench.
REQ-032 Accumulator never wraps for N_IN<=MAX_IN (|acc| <= 64*128*128 < 2^23).

Reset
REQ-033 Reset in any state -> IDLE next edge; dut_busy=0, fc_error=0, write enable=0, all addresses=0, accumulator and counters cleared.
REQ-034 Reset mid-operation issues no further scratchpad writes; in-progress word is discarded.
REQ-035 Start asserted in the same cycle as reset is ignored.

Verification
REQ-036 N_IN=4, N_OUT=2, features {1,2,3,4}, weights all 1 -> scratchpad[0]=16'h0A0A, one write, dut_busy then 0.
REQ-037 N_IN=2, N_OUT=3, features {100,100}, weights row0 {1,1}, row1 {-1,-1}, row2 {0,1} -> scratchpad[0]=16'h7F00, scratchpad[1]=16'h6400.
REQ-038 Header N_IN=3 -> fc_error=1, zero writes, returns to IDLE; next valid start clears fc_error.
REQ-039 N_IN=64, all features -128, all weights -128 -> acc=1048576, result 8'h7F; no overflow.
REQ-040 Reset asserted in MAC of neuron 1 -> no write after reset; fresh start reproduces REQ-036 results.
REQ-041 dut_run held high throughout a run -> no restart until IDLE; exactly one run per IDLE acceptance.
